calc_cmd_seq: RTL and testbench



---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_cmd_seq_if.sv | 28 ++
 rtl/calc_cmd_fifo.sv | 69 ++++++
 rtl/calc_cmd_seq.sv | 179 +++++++++++++++++
 tb/tb_calc_cmd_seq.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator command sequencer: command codes,
// calc_top status codes and the sequencer FSM states.
package calc_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_ADD   = 4'b1010;
  localparam cmd_t CMD_SUB   = 4'b1011;
  localparam cmd_t CMD_MUL   = 4'b1100;
  localparam cmd_t CMD_CLEAR = 4'b1101;
  localparam cmd_t CMD_EQ    = 4'b1110;
  localparam cmd_t CMD_IDLE  = 4'b1111;

  typedef enum logic [1:0] {
    STAT_READY    = 2'b00,
    STAT_BUSY     = 2'b01,
    STAT_ERROR    = 2'b10,
    STAT_OVERFLOW = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_RDY = 2'b01,
    S_DRIVE    = 2'b10,
    S_GAP      = 2'b11
  } state_t;

  // Error and overflow from the calculator both abort the queued sequence.
  function automatic logic is_fault(input status_t s);
    return (s == STAT_ERROR) || (s == STAT_OVERFLOW);
  endfunction

endpackage

// File: rtl/calc_cmd_seq_if.sv
// Host/calculator-facing bus of the command sequencer. The master side is
// the host plus the calculator status source; the slave side is the sequencer.
interface calc_cmd_seq_if #(
  parameter int DEPTH = 8
);

  logic                     wr_en;
  logic [3:0]               wr_cmd;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic [1:0]               status;
  logic [3:0]               cmd;
  logic                     active;
  logic                     done;
  logic                     err;
  logic [1:0]               err_code;

  modport master (
    output wr_en, wr_cmd, status,
    input  full, count, cmd, active, done, err, err_code
  );

  modport slave (
    input  wr_en, wr_cmd, status,
    output full, count, cmd, active, done, err, err_code
  );

endinterface

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO. A flush empties it in one cycle and wins over any
// push or pop in the same cycle; a push while full is dropped.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == DEPTH_CNT);
  assign empty   = (occ == '0);
  assign count   = occ;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/calc_cmd_seq.sv
// Command sequencer for calc_top: queues host commands and replays them one
// at a time, waiting for READY, holding each code then idling for a gap.
module calc_cmd_seq
  import calc_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int HOLD_CYCLES    = 10,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clock,
  input  logic           reset,
  calc_cmd_seq_if.slave  bus
);

  localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int WW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  state_t                 state_n;
  cmd_t                   cmd_q;
  cmd_t                   cmd_n;
  logic [PW-1:0]          ph_cnt;
  logic [PW-1:0]          ph_n;
  logic [WW-1:0]          wait_cnt;
  logic [WW-1:0]          wait_n;
  logic                   done_q;
  logic                   done_n;
  logic                   err_q;
  logic                   err_n;
  logic [1:0]             err_code_q;
  logic [1:0]             err_code_n;

  logic                   fifo_pop;
  logic                   fifo_flush;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  cmd_t                   fifo_head;
  status_t                stat;

  assign stat = status_t'(bus.status);

  calc_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.wr_en),
    .din   (cmd_t'(bus.wr_cmd)),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;
  assign bus.cmd      = cmd_q;
  assign bus.active   = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs and counters, so cmd only ever changes on a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q      <= CMD_IDLE;
      ph_cnt     <= '0;
      wait_cnt   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      cmd_q      <= cmd_n;
      ph_cnt     <= ph_n;
      wait_cnt   <= wait_n;
      done_q     <= done_n;
      err_q      <= err_n;
      err_code_q <= err_code_n;
    end
  end

  // Next state, next registered outputs and FIFO control for the sequencer.
  always_comb begin
    state_n    = state;
    cmd_n      = cmd_q;
    ph_n       = ph_cnt;
    wait_n     = wait_cnt;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_n = CMD_IDLE;
        if (!fifo_empty) begin
          state_n = S_WAIT_RDY;
          wait_n  = '0;
        end
      end

      S_WAIT_RDY: begin
        cmd_n = CMD_IDLE;
        if (stat == STAT_READY) begin
          fifo_pop = 1'b1;
          cmd_n    = fifo_head;
          ph_n     = '0;
          wait_n   = '0;
          state_n  = S_DRIVE;
        end else if (is_fault(stat)) begin
          fifo_flush = 1'b1;
          err_n      = 1'b1;
          err_code_n = stat;
          wait_n     = '0;
          state_n    = S_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          fifo_flush = 1'b1;
          err_n      = 1'b1;
          err_code_n = 2'b01;
          wait_n     = '0;
          state_n    = S_IDLE;
        end else begin
          wait_n = wait_cnt + WW'(1);
        end
      end

      S_DRIVE: begin
        if (ph_cnt == HOLD_LAST) begin
          ph_n    = '0;
          cmd_n   = CMD_IDLE;
          state_n = S_GAP;
        end else begin
          ph_n = ph_cnt + PW'(1);
        end
      end

      S_GAP: begin
        cmd_n = CMD_IDLE;
        if (ph_cnt == GAP_LAST) begin
          ph_n = '0;
          if (!fifo_empty) begin
            wait_n  = '0;
            state_n = S_WAIT_RDY;
          end else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          ph_n = ph_cnt + PW'(1);
        end
      end

      default: begin
        cmd_n   = CMD_IDLE;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_cmd_seq.sv
// Scoreboard bench for calc_cmd_seq: stimulus queues expected drive/gap/done/err
// events, a negedge monitor reconstructs the same events from the bus.
module tb_calc_cmd_seq;
  import calc_pkg::*;

  localparam int DEPTH   = 8;
  localparam int HOLD    = 10;
  localparam int GAP     = 10;
  localparam int TIMEOUT = 1000;

  localparam int EV_DRIVE = 0;
  localparam int EV_GAP   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int kind;
    int val;
    int len;
  } ev_t;

  logic clock;
  logic reset;
  ev_t  expQ [$];
  int   vectors;
  int   miscompares;

  int   runLen;
  int   runCode;
  int   gapLen;
  bit   afterDrive;

  calc_cmd_seq_if #(.DEPTH(DEPTH)) bus ();

  calc_cmd_seq #(
    .DEPTH          (DEPTH),
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic string kindName(input int k);
    case (k)
      EV_DRIVE: return "drive";
      EV_GAP:   return "gap";
      EV_DONE:  return "done";
      EV_ERR:   return "err";
      default:  return "none";
    endcase
  endfunction

  task automatic expectEvent(input int kind, input int val, input int len);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.len  = len;
    expQ.push_back(e);
  endtask

  // One command drive followed by a gap that includes the single WAIT_RDY cycle.
  task automatic expectCmd(input int code, input bit more);
    expectEvent(EV_DRIVE, code, HOLD);
    if (more) expectEvent(EV_GAP, 0, GAP + 1);
    else      expectEvent(EV_DONE, 0, GAP);
  endtask

  task automatic observe(input int kind, input int val, input int len);
    ev_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: got %s val=%0d len=%0d, required no event",
               kindName(kind), val, len);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.val != val || e.len != len) begin
        miscompares++;
        $display("[TB] FAIL scoreboard: got %s val=%0d len=%0d, required %s val=%0d len=%0d",
                 kindName(kind), val, len, kindName(e.kind), e.val, e.len);
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; leaves wr_en low at the following negedge.
  task automatic applyStimulus(input logic [3:0] code);
    bus.wr_en  = 1'b1;
    bus.wr_cmd = code;
    @(negedge clock);
    bus.wr_en  = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((bus.active || expQ.size() != 0) && n < maxCycles);
    vectors++;
    if (bus.active || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  // Monitor: rebuild drive/gap/done/err events from what the DUT presents.
  always @(negedge clock) begin
    if (reset) begin
      runLen     = 0;
      runCode    = 0;
      gapLen     = 0;
      afterDrive = 0;
    end else begin
      if (bus.err) begin
        observe(EV_ERR, int'(bus.err_code), 0);
        afterDrive = 0;
      end
      if (bus.done) begin
        observe(EV_DONE, 0, gapLen);
        afterDrive = 0;
        gapLen     = 0;
      end
      if (bus.cmd != CMD_IDLE) begin
        if (runLen == 0 && afterDrive) begin
          observe(EV_GAP, 0, gapLen);
        end else if (runLen != 0 && int'(bus.cmd) != runCode) begin
          observe(EV_DRIVE, runCode, runLen);
          runLen = 0;
        end
        runCode    = int'(bus.cmd);
        runLen++;
        afterDrive = 0;
        gapLen     = 0;
      end else begin
        if (runLen != 0) begin
          observe(EV_DRIVE, runCode, runLen);
          runLen     = 0;
          afterDrive = 1;
          gapLen     = 0;
        end
        if (afterDrive) gapLen++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit stayedIdle;
    bit seen;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_cmd  = 4'h0;
    bus.status  = STAT_READY;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("reset cmd", int'(bus.cmd), 15);
    checkOutput("reset full", int'(bus.full), 0);
    checkOutput("reset count", int'(bus.count), 0);
    checkOutput("reset active", int'(bus.active), 0);
    checkOutput("reset done", int'(bus.done), 0);
    checkOutput("reset err", int'(bus.err), 0);
    checkOutput("reset err_code", int'(bus.err_code), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Four-command sequence with READY, including first-command latency
    $display("[TB] sequence 1 A 2 E");
    expectCmd(1, 1);
    expectCmd(CMD_ADD, 1);
    expectCmd(2, 1);
    expectCmd(CMD_EQ, 0);
    applyStimulus(4'd1);
    checkOutput("latency count after push", int'(bus.count), 1);
    checkOutput("latency cmd cycle 1", int'(bus.cmd), 15);
    @(negedge clock);
    checkOutput("latency active cycle 2", int'(bus.active), 1);
    checkOutput("latency cmd cycle 2", int'(bus.cmd), 15);
    @(negedge clock);
    checkOutput("latency cmd cycle 3", int'(bus.cmd), 1);
    applyStimulus(CMD_ADD);
    applyStimulus(4'd2);
    applyStimulus(CMD_EQ);
    waitIdle("sequence drain", 200);
    checkOutput("sequence count drained", int'(bus.count), 0);

    // BUSY for 50 cycles, then READY
    $display("[TB] busy then ready");
    bus.status = STAT_BUSY;
    expectCmd(5, 0);
    applyStimulus(4'd5);
    stayedIdle = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.cmd != CMD_IDLE) stayedIdle = 0;
    end
    checkOutput("cmd idle while busy", int'(stayedIdle), 1);
    bus.status = STAT_READY;
    waitIdle("busy-ready drain", 100);

    // Permanent BUSY: timeout after TIMEOUT wait cycles
    $display("[TB] timeout");
    bus.status = STAT_BUSY;
    expectEvent(EV_ERR, 1, 0);
    applyStimulus(4'd3);
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < TIMEOUT + 200; i++) begin
      @(negedge clock);
      if (bus.err) begin
        seen = 1;
        break;
      end
      if (bus.active) cnt++;
    end
    checkOutput("timeout err seen", int'(seen), 1);
    checkOutput("timeout wait cycles", cnt, TIMEOUT);
    checkOutput("timeout err_code", int'(bus.err_code), 1);
    checkOutput("timeout count flushed", int'(bus.count), 0);
    @(negedge clock);

    // Overfill while BUSY: two pushes dropped, DEPTH replayed in order
    $display("[TB] overfill");
    for (int i = 0; i < DEPTH; i++) expectCmd(i, i != DEPTH - 1);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(4'(i));
    checkOutput("overfill full", int'(bus.full), 1);
    checkOutput("overfill count", int'(bus.count), DEPTH);
    bus.status = STAT_READY;
    waitIdle("overfill drain", 400);
    checkOutput("overfill count drained", int'(bus.count), 0);
    checkOutput("overfill full cleared", int'(bus.full), 0);

    // ERROR while waiting with three queued; push in the abort cycle is dropped
    $display("[TB] error abort");
    bus.status = STAT_BUSY;
    expectEvent(EV_ERR, 2, 0);
    applyStimulus(CMD_MUL);
    applyStimulus(CMD_CLEAR);
    applyStimulus(4'd4);
    checkOutput("error pre count", int'(bus.count), 3);
    bus.status = STAT_ERROR;
    bus.wr_en  = 1'b1;
    bus.wr_cmd = 4'd6;
    @(negedge clock);
    bus.wr_en  = 1'b0;
    bus.status = STAT_BUSY;
    checkOutput("error err pulse", int'(bus.err), 1);
    checkOutput("error err_code", int'(bus.err_code), 2);
    checkOutput("error count flushed", int'(bus.count), 0);
    checkOutput("error active", int'(bus.active), 0);
    @(negedge clock);
    checkOutput("error err one cycle", int'(bus.err), 0);
    checkOutput("error err_code held", int'(bus.err_code), 2);
    checkOutput("error stays idle", int'(bus.active), 0);

    // Reset during DRIVE of command 7
    $display("[TB] reset mid-drive");
    bus.status = STAT_READY;
    applyStimulus(4'd7);
    applyStimulus(4'd8);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd == 4'd7) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    checkOutput("reset-test cmd 7 reached", int'(seen), 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset cmd", int'(bus.cmd), 15);
    checkOutput("async reset count", int'(bus.count), 0);
    checkOutput("async reset active", int'(bus.active), 0);
    @(negedge clock);
    #2 reset = 1'b0;
    stayedIdle = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.cmd != CMD_IDLE || bus.active || bus.done) stayedIdle = 0;
    end
    checkOutput("post-reset quiet", int'(stayedIdle), 1);
    expectCmd(9, 0);
    applyStimulus(4'd9);
    waitIdle("post-reset resume", 100);

    while (expQ.size() != 0) begin
      ev_t e;
      e = expQ.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard leftover: got nothing, required %s val=%0d len=%0d",
               kindName(e.kind), e.val, e.len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
